regfile_write_scheduler: RTL and testbench

Shares the single register-file write port among `NREQ` requesters with round-robin arbitration. Each accepted write is registered and turned into a one-hot 32-bit write enable through a 5-to-32 decoder stage. A built-in CLEAR sequencer zeroes registers 1..31, one per cycle. The block sits between the execute/load units and the 32×32 register file; register 0 is hardwired to zero and is never written.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wr_decoder5to32.sv | 17 +
 rtl/regfile_write_scheduler.sv | 156 +++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register-file write scheduler.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_N  = 32;

    localparam logic [REG_AW-1:0] CLEAR_LAST = 5'd31;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wr_state_e;

endpackage

// File: rtl/wr_decoder5to32.sv
// 5-to-32 one-hot decoder with an enable; all-zero output when disabled.
module wr_decoder5to32
    import regfile_pkg::*;
(
    input  logic              en,
    input  logic [REG_AW-1:0] addr,
    output logic [REG_N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Round-robin arbitration of NREQ writers onto the single register-file write
// port, with a CLEAR sequencer that zeroes registers 1..31 one per cycle.
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 stall,
    input  logic                 clear_start,
    output logic [REG_N-1:0]     wr_en,
    output logic [REG_AW-1:0]    wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic                 dbg_state,
    output logic [2:0]           dbg_rr,
    output logic [REG_AW-1:0]    dbg_cc
);

    wr_state_e           state_q, state_d;
    logic [2:0]          rr_q, rr_d;
    logic [REG_AW-1:0]   cc_q, cc_d;
    logic                issue_q, issue_d;
    logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]       wr_data_q, wr_data_d;
    logic                done_q, done_d;

    logic                grant_vld;
    logic [2:0]          grant_idx;
    logic                arb_en;
    logic                xfer;
    logic [REG_AW-1:0]   sel_addr;
    logic [DW-1:0]       sel_data;
    int                  cand;

    // Rotating search: offset k from rr maps to requester (rr + k) mod NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_vld && (i == cand) && req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = 3'(i);
                end
            end
        end
    end

    assign arb_en = (state_q == IDLE) && !stall && !clear_start && !reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = arb_en && grant_vld && (grant_idx == 3'(i));
        end
    end

    assign xfer = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_addr = req_addr[5*i +: 5];
                sel_data = req_data[DW*i +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cc_d      = cc_q;
        issue_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start && !stall) begin
                    state_d = CLEAR;
                    cc_d    = 5'd1;
                end else if (xfer) begin
                    issue_d   = 1'b1;
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                    rr_d      = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;
                end
            end
            CLEAR: begin
                if (!stall) begin
                    issue_d   = 1'b1;
                    wr_addr_d = cc_q;
                    wr_data_d = '0;
                    if (cc_q == CLEAR_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cc_d = cc_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= 3'd0;
            cc_q      <= '0;
            issue_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cc_q      <= cc_d;
            issue_q   <= issue_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Register 0 is hardwired: its writes are consumed but never enabled.
    wr_decoder5to32 u_dec (
        .en     (issue_q && (wr_addr_q != '0)),
        .addr   (wr_addr_q),
        .onehot (wr_en)
    );

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign clear_busy = (state_q == CLEAR);
    assign clear_done = done_q;
    assign dbg_state  = (state_q == CLEAR);
    assign dbg_rr     = rr_q;
    assign dbg_cc     = cc_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_regfile_write_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              stall;
    logic              clear_start;
    logic [31:0]       wr_en;
    logic [4:0]        wr_addr;
    logic [DW-1:0]     wr_data;
    logic              clear_busy;
    logic              clear_done;
    logic              dbg_state;
    logic [2:0]        dbg_rr;
    logic [4:0]        dbg_cc;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // Model state: what the outputs must show after the most recent edge.
    int          m_rr, m_cc, m_grant;
    bit          m_clear, m_done;
    logic [31:0] m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_ready;

    regfile_write_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .stall(stall),
        .clear_start(clear_start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clear_busy(clear_busy), .clear_done(clear_done),
        .dbg_state(dbg_state), .dbg_rr(dbg_rr), .dbg_cc(dbg_cc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_rr = 0; m_cc = 0; m_clear = 0; m_done = 0;
        m_en = '0; m_addr = '0; m_data = '0; m_grant = -1; m_ready = '0;
    endtask

    task automatic model_eval();
        m_grant = -1;
        m_ready = '0;
        if (!reset && !m_clear && !stall && !clear_start) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_grant < 0 && req_valid[(m_rr + k) % NREQ])
                    m_grant = (m_rr + k) % NREQ;
            end
        end
        if (m_grant >= 0) m_ready[m_grant] = 1'b1;
    endtask

    // Advance one clock: model computes the next outputs from current inputs.
    task automatic tick();
        logic [31:0] n_en;
        logic [4:0]  n_addr, a;
        logic [31:0] n_data;
        bit          n_clear, n_done;
        model_eval();
        n_en = '0; n_done = 0; n_addr = m_addr; n_data = m_data; n_clear = m_clear;
        if (!m_clear) begin
            if (m_grant >= 0) begin
                a      = req_addr[5*m_grant +: 5];
                n_addr = a;
                n_data = req_data[DW*m_grant +: DW];
                n_en   = (a == 5'd0) ? 32'h0 : (32'h1 << a);
                m_rr   = (m_grant + 1) % NREQ;
            end else if (clear_start && !stall) begin
                n_clear = 1;
                m_cc    = 1;
            end
        end else if (!stall) begin
            n_addr = 5'(m_cc);
            n_data = '0;
            n_en   = 32'h1 << m_cc;
            if (m_cc == 31) begin
                n_clear = 0;
                n_done  = 1;
            end else begin
                m_cc = m_cc + 1;
            end
        end
        @(posedge clk);
        m_en = n_en; m_addr = n_addr; m_data = n_data; m_clear = n_clear; m_done = n_done;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_addr = '0; req_data = '0; stall = 0; clear_start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        req_valid = '1;
        repeat (2) @(negedge clk);
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        n_vec++; if (wr_en !== 32'h0) begin n_err++; $display("FAIL rst_wr_en: got %h want 0", wr_en); end
        n_vec++; if (wr_addr !== 5'd0 || wr_data !== 32'h0) begin n_err++; $display("FAIL rst_wr: got %h/%h want 0/0", wr_addr, wr_data); end
        n_vec++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin n_err++; $display("FAIL rst_clear: got %b%b want 00", clear_busy, clear_done); end
        n_vec++; if (dbg_rr !== 3'd0 || dbg_cc !== 5'd0 || dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state: rr %0d cc %0d st %b want 0", dbg_rr, dbg_cc, dbg_state); end
        reset = 0;
        idle_inputs();
        model_reset();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_addr[10 +: 5] = 5'd7;
        req_data[64 +: 32] = 32'hDEADBEEF;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        req_data = '0;
        n_vec++; if (wr_en !== 32'h0000_0080) begin n_err++; $display("FAIL single_wr_en: got %h want 00000080", wr_en); end
        n_vec++; if (wr_data !== 32'hDEADBEEF || wr_addr !== 5'd7) begin n_err++; $display("FAIL single_wr: got %h/%h want 07/deadbeef", wr_addr, wr_data); end
        n_vec++; if (dbg_rr !== 3'd3) begin n_err++; $display("FAIL single_rr: got %0d want 3", dbg_rr); end
        tick();
        n_vec++; if (wr_en !== 32'h0 || wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold: got %h/%h want 0/deadbeef", wr_en, wr_data); end
    endtask

    task automatic test_round_robin();
        logic [31:0] g;
        req_valid = 4'b1000;
        req_addr[15 +: 5] = 5'd20;
        tick();
        n_vec++; if (dbg_rr !== 3'd0) begin n_err++; $display("FAIL rr_prime: got %0d want 0", dbg_rr); end
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[5*i +: 5] = 5'(i + 1);
            req_data[DW*i +: DW] = 32'h100 + i;
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) exp_q.push_back(i);
        while (exp_q.size() > 0) begin
            g = exp_q.pop_front();
            #1;
            n_vec++; if (req_ready !== (4'b1 << g)) begin n_err++; $display("FAIL rr_grant: got %b want %b", req_ready, 4'b1 << g); end
            tick();
            n_vec++; if (wr_en !== (32'h1 << (g + 1))) begin n_err++; $display("FAIL rr_wr_en: got %h want %h", wr_en, 32'h1 << (g + 1)); end
        end
        idle_inputs();
    endtask

    task automatic test_addr0();
        req_valid = 4'b0001;
        req_addr[0 +: 5] = 5'd0;
        req_data[0 +: 32] = 32'h1234;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL a0_ready: got %b want 0001", req_ready); end
        tick();
        idle_inputs();
        n_vec++; if (wr_en !== 32'h0) begin n_err++; $display("FAIL a0_wr_en: got %h want 0", wr_en); end
        n_vec++; if (wr_addr !== 5'd0 || wr_data !== 32'h1234) begin n_err++; $display("FAIL a0_wr: got %h/%h want 00/00001234", wr_addr, wr_data); end
        n_vec++; if (dbg_rr !== 3'(m_rr)) begin n_err++; $display("FAIL a0_rr: got %0d want %0d", dbg_rr, m_rr); end
    endtask

    task automatic test_clear_stall();
        int next_addr = 1;
        int done_cnt = 0;
        bit fin = 0;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) req_addr[5*i +: 5] = 5'(i + 3);
        clear_start = 1;
        #1;
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL clr_start_ready: got %b want 0000", req_ready); end
        tick();
        clear_start = 0;
        for (int c = 0; c < 60 && !fin; c++) begin
            stall = (c >= 8 && c <= 10);
            #1;
            n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL clr_ready: got %b want 0000 cycle %0d", req_ready, c); end
            tick();
            if (stall) begin
                n_vec++; if (wr_en !== 32'h0) begin n_err++; $display("FAIL clr_pause: got %h want 0", wr_en); end
            end else begin
                n_vec++; if (wr_en !== (32'h1 << next_addr)) begin n_err++; $display("FAIL clr_walk: got %h want %h", wr_en, 32'h1 << next_addr); end
                next_addr++;
            end
            if (clear_done) begin done_cnt++; fin = 1; end
        end
        idle_inputs();
        n_vec++; if (next_addr !== 32 || done_cnt !== 1) begin n_err++; $display("FAIL clr_end: issued to %0d done %0d want 32/1", next_addr, done_cnt); end
        n_vec++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL clr_busy_end: got %b want 0", clear_busy); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL clr_done_once: got %b want 0", clear_done); end
        end
    endtask

    task automatic test_simultaneous();
        bit seen = 0;
        req_valid = 4'b0010;
        req_addr[5 +: 5] = 5'd9;
        req_data[32 +: 32] = 32'hCAFE0001;
        clear_start = 1;
        #1;
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL sim_ready: got %b want 0000", req_ready); end
        tick();
        clear_start = 0;
        n_vec++; if (clear_busy !== 1'b1) begin n_err++; $display("FAIL sim_busy: got %b want 1", clear_busy); end
        for (int c = 0; c < 60 && !seen; c++) begin
            #1;
            if (clear_done) begin
                seen = 1;
                n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL sim_first_grant: got %b want 0010", req_ready); end
                tick();
                n_vec++; if (wr_en !== 32'h200 || wr_data !== 32'hCAFE0001) begin n_err++; $display("FAIL sim_wr: got %h/%h want 00000200/cafe0001", wr_en, wr_data); end
            end else begin
                n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL sim_busy_ready: got %b want 0000", req_ready); end
                tick();
            end
        end
        if (!seen) begin n_vec++; n_err++; $display("FAIL sim_timeout: clear_done got 0 want 1 within 60 cycles"); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clear_start = 1;
        tick();
        clear_start = 0;
        req_valid = 4'hF;
        for (int c = 0; c < 40 && dbg_cc != 5'd10; c++) tick();
        n_vec++; if (dbg_cc !== 5'd10 || m_cc != 10) begin n_err++; $display("FAIL rmc_reach: got cc %0d want 10 (model %0d)", dbg_cc, m_cc); end
        #2 reset = 1;
        #1;
        n_vec++; if (wr_en !== 32'h0 || wr_addr !== 5'd0 || wr_data !== 32'h0) begin n_err++; $display("FAIL rmc_wr: got %h/%h/%h want 0", wr_en, wr_addr, wr_data); end
        n_vec++; if (clear_busy !== 1'b0 || clear_done !== 1'b0 || req_ready !== 4'b0) begin n_err++; $display("FAIL rmc_ctl: got %b%b %b want 00 0000", clear_busy, clear_done, req_ready); end
        n_vec++; if (dbg_cc !== 5'd0 || dbg_state !== 1'b0) begin n_err++; $display("FAIL rmc_state: got cc %0d st %b want 0/0", dbg_cc, dbg_state); end
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        idle_inputs();
        model_reset();
        for (int c = 0; c < 35; c++) begin
            tick();
            n_vec++; if (clear_done !== 1'b0 || clear_busy !== 1'b0 || wr_en !== 32'h0) begin n_err++; $display("FAIL rmc_after: got done %b busy %b en %h want 0", clear_done, clear_busy, wr_en); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                req_addr[5*i +: 5] = 5'($urandom_range(0, 31));
                req_data[DW*i +: DW] = $urandom;
            end
            stall = ($urandom_range(0, 7) == 0);
            clear_start = ($urandom_range(0, 49) == 0);
            #1;
            model_eval();
            n_vec++; if (req_ready !== m_ready) begin n_err++; $display("FAIL rnd_ready: got %b want %b", req_ready, m_ready); end
            tick();
            n_vec++; if (wr_en !== m_en) begin n_err++; $display("FAIL rnd_wr_en: got %h want %h", wr_en, m_en); end
            n_vec++; if (wr_addr !== m_addr || wr_data !== m_data) begin n_err++; $display("FAIL rnd_wr: got %h/%h want %h/%h", wr_addr, wr_data, m_addr, m_data); end
            n_vec++; if (clear_busy !== m_clear || clear_done !== m_done) begin n_err++; $display("FAIL rnd_clear: got %b%b want %b%b", clear_busy, clear_done, m_clear, m_done); end
            n_vec++; if (dbg_rr !== 3'(m_rr)) begin n_err++; $display("FAIL rnd_rr: got %0d want %0d", dbg_rr, m_rr); end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_addr0();
        test_clear_stall();
        test_simultaneous();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
